// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared types and constants for the stopwatch run controller.
//               Run-state enumeration and the seconds/minutes field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_PAUSED   = 2'd2,
        ST_OVERFLOW = 2'd3
    } sw_state_t;

endpackage
`default_nettype wire

// File: rtl/stopwatch_ctrl_tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Divides clk by CLK_HZ while run is high and emits a
//               registered one-cycle strobe the cycle after the divider wraps.
//               The divider holds its value while run is low, so a paused
//               second is finished after resume.
// Ports       : clk    - system clock
//               rst    - asynchronous active-high reset
//               run    - advance the divider this cycle
//               clr    - synchronous clear of divider and strobe
//               strobe - one-cycle pulse, CLK_HZ run-cycles apart
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic strobe
);

    localparam int c_cnt_w = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLK_HZ - 1);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_strobe;
    logic               w_wrap;

    assign w_wrap = run && (r_cnt == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else if (clr) begin
            r_cnt    <= '0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_wrap;
            if (run) begin
                r_cnt <= w_wrap ? '0 : (r_cnt + c_one);
            end
        end
    end

    assign strobe = r_strobe;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Run-control sequencer for the stopwatch seconds datapath.
//               Run FSM (IDLE/RUNNING/PAUSED/OVERFLOW), 1 Hz count_en strobe,
//               minute counter, saturation at (MAX_MIN-1):59 and display mux.
//               Optional lap freeze is built when STOPWATCH_LAP_EN is defined.
// Ports       : clk, rst (async, active-high)
//               start_stop, clear, lap  - single-cycle control pulses
//               sec_value, sec_tick     - from the external seconds counter
//               count_en, counter_clr   - to the external seconds counter
//               minutes, disp_sec, disp_min, running, overflow, lap_active
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int MAX_MIN = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_stop,
    input  logic             clear,
    input  logic             lap,
    input  logic [SEC_W-1:0] sec_value,
    input  logic             sec_tick,
    output logic             count_en,
    output logic             counter_clr,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] disp_sec,
    output logic [MIN_W-1:0] disp_min,
    output logic             running,
    output logic             overflow,
    output logic             lap_active
);

    localparam logic [MIN_W-1:0] c_min_last = MIN_W'(MAX_MIN - 1);
    localparam logic [MIN_W-1:0] c_min_one  = MIN_W'(1);

    sw_state_t        r_state;
    sw_state_t        w_next_state;
    logic [MIN_W-1:0] r_min;
    logic             r_counter_clr;
    logic             w_run;
    logic             w_strobe;
    logic             w_strobe_live;
    logic             w_at_max;

    // The prescaler strobe lands one cycle after the wrap; gating it with the
    // current state drops it when a pause, clear or saturation took effect on
    // the wrap edge, so count_en stays a pure function of registers.
    assign w_run         = (r_state == ST_RUNNING);
    assign w_at_max      = (r_min == c_min_last) && (sec_value == SEC_MAX);
    assign w_strobe_live = w_strobe && w_run;

    tick_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .run    (w_run),
        .clr    (clear),
        .strobe (w_strobe)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; clear dominates, saturation dominates start_stop
    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     if (start_stop) w_next_state = ST_RUNNING;
                ST_RUNNING: begin
                    if (w_strobe_live && w_at_max) w_next_state = ST_OVERFLOW;
                    else if (start_stop)           w_next_state = ST_PAUSED;
                end
                ST_PAUSED:   if (start_stop) w_next_state = ST_RUNNING;
                ST_OVERFLOW: w_next_state = ST_OVERFLOW;
                default:     w_next_state = ST_IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        running  = (r_state == ST_RUNNING);
        overflow = (r_state == ST_OVERFLOW);
        count_en = w_strobe_live && !w_at_max;
    end

    // Minute counter and registered clear pulse to the seconds counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min         <= '0;
            r_counter_clr <= 1'b0;
        end else begin
            r_counter_clr <= clear;
            if (clear) begin
                r_min <= '0;
            end else if (sec_tick && (r_min != c_min_last)) begin
                r_min <= r_min + c_min_one;
            end
        end
    end

    assign counter_clr = r_counter_clr;
    assign minutes     = r_min;

`ifdef STOPWATCH_LAP_EN
    logic [MIN_W-1:0] r_lap_min;
    logic [SEC_W-1:0] r_lap_sec;
    logic             r_lap_active;

    // A lap pulse releases an active freeze in any state; a new freeze is
    // only taken while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lap_min    <= '0;
            r_lap_sec    <= '0;
            r_lap_active <= 1'b0;
        end else if (clear) begin
            r_lap_active <= 1'b0;
        end else if (lap) begin
            if (r_lap_active) begin
                r_lap_active <= 1'b0;
            end else if (r_state == ST_RUNNING) begin
                r_lap_min    <= r_min;
                r_lap_sec    <= sec_value;
                r_lap_active <= 1'b1;
            end
        end
    end

    assign lap_active = r_lap_active;
    assign disp_sec   = r_lap_active ? r_lap_sec : sec_value;
    assign disp_min   = r_lap_active ? r_lap_min : r_min;
`else
    logic w_unused_lap;
    assign w_unused_lap = lap;
    assign lap_active   = 1'b0;
    assign disp_sec     = sec_value;
    assign disp_min     = r_min;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Scoreboard bench for stopwatch_ctrl (CLK_HZ=4, MAX_MIN=2).
//               Models the external seconds counter, predicts every cycle's
//               outputs from the stopwatch rules, and compares in a separate
//               monitor process.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    localparam int CLK_HZ  = 4;
    localparam int MAX_MIN = 2;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_OVF   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic [5:0] sec_value;
    logic       sec_tick;
    logic       count_en;
    logic       counter_clr;
    logic [5:0] minutes;
    logic [5:0] disp_sec;
    logic [5:0] disp_min;
    logic       running;
    logic       overflow;
    logic       lap_active;

    stopwatch_ctrl #(
        .CLK_HZ  (CLK_HZ),
        .MAX_MIN (MAX_MIN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_stop  (start_stop),
        .clear       (clear),
        .lap         (lap),
        .sec_value   (sec_value),
        .sec_tick    (sec_tick),
        .count_en    (count_en),
        .counter_clr (counter_clr),
        .minutes     (minutes),
        .disp_sec    (disp_sec),
        .disp_min    (disp_min),
        .running     (running),
        .overflow    (overflow),
        .lap_active  (lap_active)
    );

    always #5 clk = ~clk;

    // External seconds counter (environment)
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              sec_value <= '0;
        else if (counter_clr) sec_value <= '0;
        else if (count_en)    sec_value <= (sec_value == 6'd59) ? 6'd0 : sec_value + 6'd1;
    end
    assign sec_tick = count_en && (sec_value == 6'd59);

    typedef struct {
        int count_en;
        int counter_clr;
        int minutes;
        int disp_sec;
        int disp_min;
        int running;
        int overflow;
        int lap_active;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference model state: elapsed time, run mode and phase within a second
    int m_mode, m_phase, m_sec, m_min, m_lap_sec, m_lap_min;
    bit m_strobe, m_cclr, m_lap_on;

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_phase = 0; m_sec = 0; m_min = 0;
        m_lap_sec = 0; m_lap_min = 0; m_strobe = 0; m_cclr = 0; m_lap_on = 0;
    endtask

    function automatic bit at_max();
        return (m_min == MAX_MIN - 1) && (m_sec == 59);
    endfunction

    function automatic bit exp_en();
        return m_strobe && (m_mode == M_RUN) && !at_max();
    endfunction

    // Advance the model across one clock edge with the given pulses, then
    // queue the outputs expected after that edge.
    task automatic model_step(input bit ss, input bit cl, input bit lp);
        exp_t e;
        bit   en, sat;
        int   n_sec, n_min, n_mode, n_phase;
        bit   n_strobe;
        en  = exp_en();
        sat = m_strobe && (m_mode == M_RUN) && at_max();
        n_sec = m_sec;
        n_min = m_min;
        if (m_cclr) n_sec = 0;
        else if (en) begin
            if (m_sec == 59) begin n_sec = 0; n_min = m_min + 1; end
            else n_sec = m_sec + 1;
        end
        n_strobe = (m_mode == M_RUN) && (m_phase == CLK_HZ - 1);
        n_phase  = (m_mode == M_RUN) ? (m_phase + 1) % CLK_HZ : m_phase;
        if (cl)                            n_mode = M_IDLE;
        else if (sat)                      n_mode = M_OVF;
        else if (ss && m_mode != M_OVF)    n_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
        else                               n_mode = m_mode;
        if (cl) begin
            n_min = 0; n_phase = 0; n_strobe = 0;
        end
        if (cl) m_lap_on = 0;
        else if (LAP_EN && lp) begin
            if (m_lap_on) m_lap_on = 0;
            else if (m_mode == M_RUN) begin
                m_lap_on = 1; m_lap_min = m_min; m_lap_sec = m_sec;
            end
        end
        m_sec = n_sec; m_min = n_min; m_mode = n_mode; m_phase = n_phase;
        m_strobe = n_strobe; m_cclr = cl;
        e.count_en    = int'(exp_en());
        e.counter_clr = int'(m_cclr);
        e.minutes     = m_min;
        e.disp_sec    = m_lap_on ? m_lap_sec : m_sec;
        e.disp_min    = m_lap_on ? m_lap_min : m_min;
        e.running     = int'(m_mode == M_RUN);
        e.overflow    = int'(m_mode == M_OVF);
        e.lap_active  = int'(m_lap_on);
        q.push_back(e);
    endtask

    task automatic cyc(input bit ss, input bit cl, input bit lp);
        @(negedge clk);
        start_stop = ss; clear = cl; lap = lp;
        model_step(ss, cl, lp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compares the DUT against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("count_en",    int'(count_en),    e.count_en);
                chk("counter_clr", int'(counter_clr), e.counter_clr);
                chk("minutes",     int'(minutes),     e.minutes);
                chk("disp_sec",    int'(disp_sec),    e.disp_sec);
                chk("disp_min",    int'(disp_min),    e.disp_min);
                chk("running",     int'(running),     e.running);
                chk("overflow",    int'(overflow),    e.overflow);
                chk("lap_active",  int'(lap_active),  e.lap_active);
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("rst_running",     int'(running),     0);
        chk("rst_overflow",    int'(overflow),    0);
        chk("rst_count_en",    int'(count_en),    0);
        chk("rst_counter_clr", int'(counter_clr), 0);
        chk("rst_minutes",     int'(minutes),     0);
        chk("rst_disp_sec",    int'(disp_sec),    0);
        chk("rst_lap_active",  int'(lap_active),  0);
        @(negedge clk);
        rst = 1'b0;

        // Start and run three seconds
        cyc(1'b1, 1'b0, 1'b0);
        idle(12);
        // Pause two cycles into a period, stay paused, resume
        idle(1);
        cyc(1'b1, 1'b0, 1'b0);
        idle(10);
        cyc(1'b1, 1'b0, 1'b0);
        idle(6);
        // Through the minute rollover, then into saturation
        idle(60 * CLK_HZ);
        idle(70 * CLK_HZ);
        cyc(1'b1, 1'b0, 1'b0);
        idle(5);
        cyc(1'b0, 1'b1, 1'b0);
        idle(3);
        // clear and start_stop together while running
        cyc(1'b1, 1'b0, 1'b0);
        idle(9);
        cyc(1'b1, 1'b1, 1'b0);
        idle(3);
        // Lap freeze at 00:05, release at 00:09
        cyc(1'b1, 1'b0, 1'b0);
        idle(5 * CLK_HZ + 2);
        cyc(1'b0, 1'b0, 1'b1);
        idle(4 * CLK_HZ);
        cyc(1'b0, 1'b0, 1'b1);
        idle(4);

        // Randomized pulses
        for (int i = 0; i < 2000; i++) begin
            bit ss, cl, lp;
            ss = ($urandom_range(0, 39) == 0);
            cl = ($urandom_range(0, 299) == 0);
            lp = ($urandom_range(0, 29) == 0);
            cyc(ss, cl, lp);
        end

        // Asynchronous reset in the middle of a run past one minute
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        idle(250);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_running",  int'(running),  0);
        chk("arst_minutes",  int'(minutes),  0);
        chk("arst_count_en", int'(count_en), 0);
        chk("arst_disp_sec", int'(disp_sec), 0);
        chk("arst_disp_min", int'(disp_min), 0);
        repeat (2) @(posedge clk);
        #2;
        chk("arst_hold_count_en", int'(count_en), 0);
        chk("arst_hold_running",  int'(running),  0);
        chk("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
